and_event_debounce_counter: RTL
===============================

Name: and_event_debounce_counter

Overview:
- Downstream consumer of the single-bit `And2` output of the 2-input AND stage; that output drives `I` here.
- Synchronises and debounces the level, then counts filtered rising edges into a pending-event register.
- Reports the pending count to a downstream sink over a valid/ready handshake, with sticky overflow flagging.

Parameters:
- WIDTH, 8, width of pending event count `O_count`.
- DB_CYCLES, 4, consecutive differing samples required to flip the filtered level; legal range 1..255.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- ASYNCRESETN  input  1  asynchronous active-low reset.
- I  input  1  raw AND result from upstream, asynchronous to CLK.
- CLR  input  1  synchronous clear of count, overflow and handshake state.
- O_ready  input  1  sink accepts the report this cycle.
- O_valid  output  1  pending count is nonzero and offered.
- O_count  output  WIDTH  pending rising-edge count.
- O_overflow  output  1  sticky: an edge was lost while count was saturated.
- O_level  output  1  current debounced level.

Behaviour:
Reset:
- One clock, CLK. Reset ASYNCRESETN is asynchronous, active-low: assertion clears all state immediately, independent of CLK.
- Values held during reset: s1=0, s2=0, filtered level=0, db count=0, O_count=0, O_valid=0, O_overflow=0, O_level=0.
- Deassertion is synchronous to CLK by the integrator. Reset mid-debounce or mid-handshake discards all progress; no report is emitted for a partially debounced edge.

Synchroniser:
- Two flops, s1<=I, s2<=s1.

Debounce FSM: states LO, HI (= O_level), plus counter dbc (width ceil(log2(DB_CYCLES+1))).
- Each edge with s2 != level: if dbc==DB_CYCLES-1, flip the level and set dbc=0; otherwise dbc++.
- Each edge with s2 == level: dbc=0 (glitch rejected).
- A LO->HI flip generates an internal rise event in the same edge. HI->LO generates nothing.
- Latency: I held stable from before edge k gives O_level and the count update visible after edge k+1+DB_CYCLES.

Pending count, evaluated per edge in priority order:
1. CLR=1: O_count=0, O_overflow=0. A rise in the same cycle is dropped. CLR does not reset the synchroniser or the FSM.
2. Handshake (O_valid & O_ready) and rise together: O_count=1, O_overflow=0.
3. Handshake only: O_count=0, O_overflow=0.
4. Rise only:
   - O_count < 2^WIDTH-1: O_count++.
   - Otherwise O_count holds at 2^WIDTH-1 and O_overflow=1.
5. Otherwise hold.

Handshake rules:
- O_valid = (O_count != 0), registered-equivalent (derived from the registered count, no combinational path from O_ready).
- O_count and O_overflow are stable while O_valid=1 and O_ready=0, except for increments from new rises. The sink samples O_count and O_overflow on the accepting edge.
- O_ready while O_valid=0 is ignored.
- No combinational path from any input to any output.

Test Plan:
- Reset: assert ASYNCRESETN low mid-cycle with O_count=3 -> all outputs 0 immediately, without a CLK edge.
- Clean pulse, DB_CYCLES=4, O_ready=0: I 0->1 before edge 10 and held -> O_level=1, O_count=1, O_valid=1 after edge 15, not earlier. I 1->0 held -> O_level=0 after 5 more edges, O_count stays 1.
- Glitch rejection: I high for exactly 3 cycles then low -> O_level stays 0, O_count=0. Repeat with 4 cycles -> count becomes 1.
- Handshake: 3 clean pulses with O_ready=0 -> O_count=3. O_ready=1 for one edge -> O_count=0, O_valid=0 next cycle. Then a rise coincident with an accepting edge (count was 2) -> O_count=1 after that edge.
- Saturation, WIDTH=2: 4 pulses, O_ready=0 -> O_count=3, O_overflow=1. Accept -> O_count=0, O_overflow=0.
- CLR: O_count=2 and CLR asserted on the same edge as a rise -> O_count=0, O_valid=0. O_level still goes 1; the next pulse counts as 1.

Source files
------------

// File: rtl/and_event_debounce_counter.sv
// and_event_debounce_counter
// Synchronises the upstream AND result, debounces it, and counts filtered
// rising edges into a pending count. The count is offered to a sink over
// valid/ready, and a sticky flag records rises lost at saturation.
module and_event_debounce_counter #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             I,
    input  logic             CLR,
    input  logic             O_ready,
    output logic             O_valid,
    output logic [WIDTH-1:0] O_count,
    output logic             O_overflow,
    output logic             O_level
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0]   DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {LO = 1'b0, HI = 1'b1} lvl_t;

    logic           s1, s2;
    lvl_t           state;
    logic [DBW-1:0] dbc;
    logic           flip;
    logic           rise;
    logic           accept;

    // A flip happens on the edge where the last required differing sample lands.
    assign flip   = (s2 != state) && (dbc == DB_LAST);
    // Only LO->HI flips are events; HI->LO flips are silent.
    assign rise   = flip && (state == LO);
    assign accept = O_valid && O_ready;

    // Two-flop synchroniser for the asynchronous input.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= I;
            s2 <= s1;
        end
    end

    // Debounce FSM: the level flips only after DB_CYCLES consecutive
    // differing samples; any agreeing sample restarts the run.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state <= LO;
            dbc   <= '0;
        end else if (s2 != state) begin
            if (dbc == DB_LAST) begin
                state <= (state == LO) ? HI : LO;
                dbc   <= '0;
            end else begin
                dbc <= dbc + 1'b1;
            end
        end else begin
            dbc <= '0;
        end
    end

    // Pending count and sticky overflow: clear beats handshake beats rise.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            O_count    <= '0;
            O_overflow <= 1'b0;
        end else if (CLR) begin
            O_count    <= '0;
            O_overflow <= 1'b0;
        end else if (accept && rise) begin
            O_count    <= WIDTH'(1);
            O_overflow <= 1'b0;
        end else if (accept) begin
            O_count    <= '0;
            O_overflow <= 1'b0;
        end else if (rise) begin
            if (O_count != CNT_MAX) begin
                O_count <= O_count + 1'b1;
            end else begin
                O_overflow <= 1'b1;
            end
        end
    end

    // Outputs come straight from registers; O_ready never reaches them combinationally.
    assign O_valid = (O_count != '0);
    assign O_level = (state == HI);

endmodule
